// File: rtl/ddr3_settings.sv
// ============================================================================
// Module      : ddr3_settings (package)
// Description : Shared DDR3 data-layer definitions. Holds the {RAS#,CAS#,WE#}
//               command codes, the timer slot indices used by the command
//               acceptor, the refresh FSM state type and the default timing
//               values (in controller clocks) derived from DDR_FREQ_MHZ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_settings;

    // Controller clock frequency used to derive the default timings.
    localparam int DDR_FREQ_MHZ = 100;

    // Round a picosecond figure up to whole controller clocks.
    function automatic int ps_to_clk(input int t_ps);
        return (t_ps * DDR_FREQ_MHZ + 999_999) / 1_000_000;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // {RAS#, CAS#, WE#} command encodings
    localparam logic [2:0] CMD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFR = 3'b001;
    localparam logic [2:0] CMD_PREC = 3'b010;
    localparam logic [2:0] CMD_ACTV = 3'b011;
    localparam logic [2:0] CMD_WRIT = 3'b100;
    localparam logic [2:0] CMD_READ = 3'b101;
    localparam logic [2:0] CMD_ZQCL = 3'b110;
    localparam logic [2:0] CMD_NOOP = 3'b111;

    // Analogue timings (DDR3-800 class figures)
    localparam int TRCD_DEF  = ps_to_clk(13_750);
    localparam int TRP_DEF   = ps_to_clk(13_750);
    localparam int TRAS_DEF  = ps_to_clk(35_000);
    localparam int TRFC_DEF  = ps_to_clk(110_000);
    localparam int TREFI_DEF = ps_to_clk(7_800_000);

    // Timings already expressed in clocks; TWR/TWTR fold in CWL and the burst.
    localparam int TWR_DEF   = 6;
    localparam int TRTP_DEF  = 2;
    localparam int TCCD_DEF  = 4;
    localparam int TWTR_DEF  = 7;
    localparam int TRTW_DEF  = 4;
    localparam int TMRD_DEF  = 4;

    // Timer slots; one global down-counter per slot (single open row).
    localparam int TMR_ACT    = 0;  // next ACT
    localparam int TMR_CAS    = 1;  // next RD/WR
    localparam int TMR_RD     = 2;  // next READ
    localparam int TMR_WR     = 3;  // next WRITE
    localparam int TMR_PRE    = 4;  // next PRE
    localparam int TMR_ANY    = 5;  // next REF/MRS/ZQCL
    localparam int NUM_TIMERS = 6;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DUE  = 2'd1,
        R_BUSY = 2'd2
    } ref_state_t;

endpackage

`default_nettype wire

// File: rtl/ddr3_delay_ctr.sv
// ============================================================================
// Module      : ddr3_delay_ctr
// Description : Saturating down-counter with load-max. On i_load the count
//               becomes max(current, i_value); otherwise it decrements by one
//               per clock and stops at zero.
// Ports       : clk, rst (async, active high)
//               i_load   - load request
//               i_value  - candidate load value
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_delay_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            // Never shorten a constraint that is already pending.
            r_count <= (i_value > r_count) ? i_value : r_count;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ddr3_ddl_timer.sv
// ============================================================================
// Module      : ddr3_ddl_timer
// Description : DDR3 data-layer command acceptor. Enforces inter-command
//               timings with global down-counters, raises ddl_rdy_o when the
//               presented command may issue, schedules periodic refresh via
//               ddl_ref_o and registers accepted commands onto the DFI bus.
// Ports       : clock, reset (async, active high)
//               ref_en_i            - enable refresh-interval counting
//               ddl_req_i/ddl_rdy_o - command handshake
//               ddl_seq_i           - same-row RD/WR follows (informational)
//               ddl_cmd_i/tid/ba/adr- command, ID, bank, row/column
//               ddl_ref_o           - refresh due / in progress
//               dfi_*               - registered DFI command outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_ddl_timer
    import ddr3_settings::*;
#(
    parameter int REQID        = 4,
    parameter int DDR_ROW_BITS = 13,
    parameter int TRCD         = TRCD_DEF,
    parameter int TRP          = TRP_DEF,
    parameter int TRAS         = TRAS_DEF,
    parameter int TRFC         = TRFC_DEF,
    parameter int TREFI        = TREFI_DEF,
    parameter int TWR          = TWR_DEF,
    parameter int TRTP         = TRTP_DEF,
    parameter int TCCD         = TCCD_DEF,
    parameter int TWTR         = TWTR_DEF,
    parameter int TRTW         = TRTW_DEF,
    parameter int TMRD         = TMRD_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ref_en_i,
    input  logic                    ddl_req_i,
    input  logic                    ddl_seq_i,
    output logic                    ddl_rdy_o,
    output logic                    ddl_ref_o,
    input  logic [2:0]              ddl_cmd_i,
    input  logic [REQID-1:0]        ddl_tid_i,
    input  logic [2:0]              ddl_ba_i,
    input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
    output logic                    dfi_cs_n_o,
    output logic                    dfi_ras_n_o,
    output logic                    dfi_cas_n_o,
    output logic                    dfi_we_n_o,
    output logic [2:0]              dfi_ba_o,
    output logic [DDR_ROW_BITS-1:0] dfi_adr_o,
    output logic                    dfi_rden_o,
    output logic                    dfi_wren_o,
    output logic [REQID-1:0]        dfi_tid_o
);

    // Longest value any timer is ever loaded with sets the counter width.
    localparam int T_MAX  = max2(max2(max2(TRCD, TRAS), max2(TCCD, TRTW)),
                                 max2(max2(TRTP + TRP, TWR + TRP),
                                      max2(max2(TWTR, TRFC), max2(TRP, TMRD))));
    localparam int CTR_W  = $clog2(T_MAX + 1);
    localparam int REFI_W = $clog2(TREFI + 1);

    logic                 r_run;
    logic                 r_open;
    ref_state_t           r_ref_state;
    logic [REFI_W-1:0]    r_refi;

    logic                 w_accept;
    logic [NUM_TIMERS-1:0] w_load;
    logic [CTR_W-1:0]     w_value [NUM_TIMERS];
    logic [CTR_W-1:0]     w_count [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] w_zero;
    logic                 w_open_set;
    logic                 w_open_clr;
    logic                 w_unused;

    // The same-row hint does not alter timing in this implementation.
    assign w_unused = ddl_seq_i;

    assign w_accept = ddl_req_i & ddl_rdy_o;

    // ------------------------------------------------------------------
    // Timers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
            ddr3_delay_ctr #(
                .WIDTH (CTR_W)
            ) u_ctr (
                .clk     (clock),
                .rst     (reset),
                .i_load  (w_load[gi]),
                .i_value (w_value[gi]),
                .o_count (w_count[gi])
            );
            assign w_zero[gi] = (w_count[gi] == '0);
        end
    endgenerate

    // Timer loads and open-row tracking for the accepted command.
    always_comb begin
        w_load     = '0;
        w_open_set = 1'b0;
        w_open_clr = 1'b0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_value[i] = '0;
        end
        if (w_accept) begin
            case (ddl_cmd_i)
                CMD_ACTV: begin
                    w_load[TMR_CAS]  = 1'b1;
                    w_value[TMR_CAS] = CTR_W'(TRCD);
                    w_load[TMR_PRE]  = 1'b1;
                    w_value[TMR_PRE] = CTR_W'(TRAS);
                    w_open_set       = 1'b1;
                end
                CMD_READ: begin
                    w_load[TMR_CAS]  = 1'b1;
                    w_value[TMR_CAS] = CTR_W'(TCCD);
                    w_load[TMR_WR]   = 1'b1;
                    w_value[TMR_WR]  = CTR_W'(TRTW);
                    w_load[TMR_PRE]  = 1'b1;
                    w_value[TMR_PRE] = CTR_W'(TRTP);
                    if (ddl_adr_i[10]) begin
                        // Auto-precharge: row closes after tRTP, then tRP.
                        w_load[TMR_ACT]  = 1'b1;
                        w_value[TMR_ACT] = CTR_W'(TRTP + TRP);
                        w_load[TMR_ANY]  = 1'b1;
                        w_value[TMR_ANY] = CTR_W'(TRTP + TRP);
                        w_open_clr       = 1'b1;
                    end
                end
                CMD_WRIT: begin
                    w_load[TMR_CAS]  = 1'b1;
                    w_value[TMR_CAS] = CTR_W'(TCCD);
                    w_load[TMR_RD]   = 1'b1;
                    w_value[TMR_RD]  = CTR_W'(TWTR);
                    w_load[TMR_PRE]  = 1'b1;
                    w_value[TMR_PRE] = CTR_W'(TWR);
                    if (ddl_adr_i[10]) begin
                        w_load[TMR_ACT]  = 1'b1;
                        w_value[TMR_ACT] = CTR_W'(TWR + TRP);
                        w_load[TMR_ANY]  = 1'b1;
                        w_value[TMR_ANY] = CTR_W'(TWR + TRP);
                        w_open_clr       = 1'b1;
                    end
                end
                CMD_PREC: begin
                    w_load[TMR_ACT]  = 1'b1;
                    w_value[TMR_ACT] = CTR_W'(TRP);
                    w_load[TMR_ANY]  = 1'b1;
                    w_value[TMR_ANY] = CTR_W'(TRP);
                    w_open_clr       = 1'b1;
                end
                CMD_REFR: begin
                    w_load[TMR_ACT]  = 1'b1;
                    w_value[TMR_ACT] = CTR_W'(TRFC);
                    w_load[TMR_ANY]  = 1'b1;
                    w_value[TMR_ANY] = CTR_W'(TRFC);
                end
                CMD_MODE, CMD_ZQCL: begin
                    w_load[TMR_ACT]  = 1'b1;
                    w_value[TMR_ACT] = CTR_W'(TMRD);
                    w_load[TMR_ANY]  = 1'b1;
                    w_value[TMR_ANY] = CTR_W'(TMRD);
                end
                default: begin
                end
            endcase
        end
    end

    // Issue permission for whatever command is presented, valid or not.
    always_comb begin
        ddl_rdy_o = 1'b0;
        case (ddl_cmd_i)
            CMD_ACTV: ddl_rdy_o = w_zero[TMR_ACT] & ~r_open;
            CMD_READ: ddl_rdy_o = r_open & w_zero[TMR_CAS] & w_zero[TMR_RD];
            CMD_WRIT: ddl_rdy_o = r_open & w_zero[TMR_CAS] & w_zero[TMR_WR];
            CMD_PREC: ddl_rdy_o = w_zero[TMR_PRE];
            CMD_REFR,
            CMD_MODE,
            CMD_ZQCL: ddl_rdy_o = w_zero[TMR_ANY] & ~r_open;
            default:  ddl_rdy_o = 1'b1;
        endcase
        ddl_rdy_o = ddl_rdy_o & r_run;
    end

    // ------------------------------------------------------------------
    // Run flag and open-row flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run  <= 1'b0;
            r_open <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_open_set) begin
                r_open <= 1'b1;
            end else if (w_open_clr) begin
                r_open <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Refresh scheduler
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ref_state <= R_IDLE;
            r_refi      <= REFI_W'(TREFI - 1);
            ddl_ref_o   <= 1'b0;
        end else if (!ref_en_i) begin
            r_ref_state <= R_IDLE;
            r_refi      <= REFI_W'(TREFI - 1);
            ddl_ref_o   <= 1'b0;
        end else begin
            case (r_ref_state)
                R_IDLE: begin
                    // A REFR accepted here only loads timers.
                    if (r_refi == '0) begin
                        r_ref_state <= R_DUE;
                        ddl_ref_o   <= 1'b1;
                    end else begin
                        r_refi <= r_refi - 1'b1;
                    end
                end
                R_DUE: begin
                    if (w_accept && (ddl_cmd_i == CMD_REFR)) begin
                        r_ref_state <= R_BUSY;
                    end
                end
                R_BUSY: begin
                    // Drop the flag exactly when tRFC expires.
                    if (w_count[TMR_ANY] == CTR_W'(1)) begin
                        r_ref_state <= R_IDLE;
                        r_refi      <= REFI_W'(TREFI - 1);
                        ddl_ref_o   <= 1'b0;
                    end
                end
                default: begin
                    r_ref_state <= R_IDLE;
                    r_refi      <= REFI_W'(TREFI - 1);
                    ddl_ref_o   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // DFI command register: accepted command for one cycle, NOP otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dfi_cs_n_o  <= 1'b1;
            dfi_ras_n_o <= 1'b1;
            dfi_cas_n_o <= 1'b1;
            dfi_we_n_o  <= 1'b1;
            dfi_ba_o    <= '0;
            dfi_adr_o   <= '0;
            dfi_rden_o  <= 1'b0;
            dfi_wren_o  <= 1'b0;
            dfi_tid_o   <= '0;
        end else begin
            dfi_cs_n_o <= 1'b0;
            if (w_accept) begin
                {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= ddl_cmd_i;
                dfi_ba_o  <= ddl_ba_i;
                dfi_adr_o <= ddl_adr_i;
            end else begin
                {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= CMD_NOOP;
            end
            dfi_rden_o <= w_accept && (ddl_cmd_i == CMD_READ);
            dfi_wren_o <= w_accept && (ddl_cmd_i == CMD_WRIT);
            if (w_accept && ((ddl_cmd_i == CMD_READ) || (ddl_cmd_i == CMD_WRIT))) begin
                dfi_tid_o <= ddl_tid_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_ddl_timer.sv
// ============================================================================
// Module      : tb_ddr3_ddl_timer
// Description : Directed self-checking bench for ddr3_ddl_timer with the
//               default timing set (TRCD=2, TRP=2, TRAS=4, TRFC=11,
//               TREFI=780, TWR=6, TCCD=4, TWTR=7, TRTW=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr3_ddl_timer;

    localparam logic [2:0] K_MODE = 3'b000;
    localparam logic [2:0] K_REFR = 3'b001;
    localparam logic [2:0] K_PREC = 3'b010;
    localparam logic [2:0] K_ACTV = 3'b011;
    localparam logic [2:0] K_WRIT = 3'b100;
    localparam logic [2:0] K_READ = 3'b101;
    localparam logic [2:0] K_ZQCL = 3'b110;
    localparam logic [2:0] K_NOOP = 3'b111;

    logic        clock = 1'b0;
    logic        reset;
    logic        ref_en_i;
    logic        ddl_req_i;
    logic        ddl_seq_i;
    logic        ddl_rdy_o;
    logic        ddl_ref_o;
    logic [2:0]  ddl_cmd_i;
    logic [3:0]  ddl_tid_i;
    logic [2:0]  ddl_ba_i;
    logic [12:0] ddl_adr_i;
    logic        dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o;
    logic [2:0]  dfi_ba_o;
    logic [12:0] dfi_adr_o;
    logic        dfi_rden_o, dfi_wren_o;
    logic [3:0]  dfi_tid_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    ddr3_ddl_timer #(
        .REQID        (4),
        .DDR_ROW_BITS (13)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .ref_en_i    (ref_en_i),
        .ddl_req_i   (ddl_req_i),
        .ddl_seq_i   (ddl_seq_i),
        .ddl_rdy_o   (ddl_rdy_o),
        .ddl_ref_o   (ddl_ref_o),
        .ddl_cmd_i   (ddl_cmd_i),
        .ddl_tid_i   (ddl_tid_i),
        .ddl_ba_i    (ddl_ba_i),
        .ddl_adr_i   (ddl_adr_i),
        .dfi_cs_n_o  (dfi_cs_n_o),
        .dfi_ras_n_o (dfi_ras_n_o),
        .dfi_cas_n_o (dfi_cas_n_o),
        .dfi_we_n_o  (dfi_we_n_o),
        .dfi_ba_o    (dfi_ba_o),
        .dfi_adr_o   (dfi_adr_o),
        .dfi_rden_o  (dfi_rden_o),
        .dfi_wren_o  (dfi_wren_o),
        .dfi_tid_o   (dfi_tid_o)
    );

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic req, input logic [2:0] cmd, input logic [2:0] ba,
                         input logic [12:0] adr, input logic [3:0] tid);
        ddl_req_i = req;
        ddl_cmd_i = cmd;
        ddl_ba_i  = ba;
        ddl_adr_i = adr;
        ddl_tid_i = tid;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ref_en_i  = 1'b0;
        ddl_seq_i = 1'b0;
        drive(1'b0, K_ACTV, 3'd0, 13'h0, 4'h0);
        repeat (2) @(negedge clock);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_cmd: got %b expected 1111", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o});
        end
        vectors++;
        if ({dfi_ba_o, dfi_adr_o, dfi_rden_o, dfi_wren_o, dfi_tid_o} !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_fields: got ba=%0h adr=%0h rden=%b wren=%b tid=%0h expected all 0",
                     dfi_ba_o, dfi_adr_o, dfi_rden_o, dfi_wren_o, dfi_tid_o);
        end
        vectors++;
        if (ddl_ref_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ref: got %b expected 0", ddl_ref_o);
        end
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rdy: got %b expected 0", ddl_rdy_o);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL release_rdy: got %b expected 0", ddl_rdy_o);
        end
        tick();
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL run_rdy: got %b expected 1", ddl_rdy_o);
        end
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 4'b0111) begin
            miscompares++;
            $display("FAIL idle_nop: got %b expected 0111", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o});
        end
    endtask

    task automatic test_act_read();
        drive(1'b1, K_ACTV, 3'd2, 13'h123, 4'h0);
        tick();
        drive(1'b0, K_READ, 3'd2, 13'h008, 4'h5);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_ba_o, dfi_adr_o} !== {4'b0011, 3'd2, 13'h123}) begin
            miscompares++;
            $display("FAIL act_dfi: got cmd=%b ba=%0h adr=%0h expected cmd=0011 ba=2 adr=123",
                     {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, dfi_ba_o, dfi_adr_o);
        end
        for (int j = 0; j < 2; j++) begin
            vectors++;
            if (ddl_rdy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL trcd_hold[%0d]: got %b expected 0", j, ddl_rdy_o);
            end
            tick();
        end
        vectors++;
        if ({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 3'b111) begin
            miscompares++;
            $display("FAIL act_one_cycle: got %b expected 111", {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o});
        end
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL trcd_done: got %b expected 1", ddl_rdy_o);
        end
    endtask

    task automatic test_read_write();
        ddl_seq_i = 1'b1;
        drive(1'b1, K_READ, 3'd2, 13'h008, 4'h5);
        tick();
        drive(1'b0, K_WRIT, 3'd2, 13'h010, 4'h9);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_rden_o, dfi_wren_o, dfi_tid_o, dfi_adr_o}
            !== {4'b0101, 1'b1, 1'b0, 4'h5, 13'h008}) begin
            miscompares++;
            $display("FAIL read_dfi: got cmd=%b rden=%b wren=%b tid=%0h adr=%0h expected 0101 1 0 5 008",
                     {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, dfi_rden_o, dfi_wren_o, dfi_tid_o, dfi_adr_o);
        end
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (ddl_rdy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL trtw_hold[%0d]: got %b expected 0", j, ddl_rdy_o);
            end
            if (j == 1) begin
                vectors++;
                if (dfi_rden_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rden_pulse: got %b expected 0", dfi_rden_o);
                end
            end
            tick();
        end
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL trtw_done: got %b expected 1", ddl_rdy_o);
        end
        drive(1'b1, K_WRIT, 3'd2, 13'h010, 4'h9);
        tick();
        ddl_seq_i = 1'b0;
        drive(1'b0, K_READ, 3'd2, 13'h020, 4'h3);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_rden_o, dfi_wren_o, dfi_tid_o}
            !== {4'b0100, 1'b0, 1'b1, 4'h9}) begin
            miscompares++;
            $display("FAIL write_dfi: got cmd=%b rden=%b wren=%b tid=%0h expected 0100 0 1 9",
                     {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, dfi_rden_o, dfi_wren_o, dfi_tid_o);
        end
        for (int j = 0; j < 7; j++) begin
            vectors++;
            if (ddl_rdy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL twtr_hold[%0d]: got %b expected 0", j, ddl_rdy_o);
            end
            tick();
        end
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL twtr_done: got %b expected 1", ddl_rdy_o);
        end
    endtask

    task automatic test_write_ap();
        drive(1'b1, K_WRIT, 3'd2, 13'h400, 4'hA);
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_rdy: got %b expected 1", ddl_rdy_o);
        end
        tick();
        drive(1'b0, K_ACTV, 3'd0, 13'h0, 4'h0);
        vectors++;
        if ({dfi_wren_o, dfi_tid_o, dfi_adr_o} !== {1'b1, 4'hA, 13'h400}) begin
            miscompares++;
            $display("FAIL wrap_dfi: got wren=%b tid=%0h adr=%0h expected 1 a 400", dfi_wren_o, dfi_tid_o, dfi_adr_o);
        end
        for (int j = 0; j < 8; j++) begin
            ddl_cmd_i = K_ACTV;
            #1;
            vectors++;
            if (ddl_rdy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_act_hold[%0d]: got %b expected 0", j, ddl_rdy_o);
            end
            ddl_cmd_i = K_REFR;
            #1;
            vectors++;
            if (ddl_rdy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_ref_hold[%0d]: got %b expected 0", j, ddl_rdy_o);
            end
            tick();
        end
        ddl_cmd_i = K_REFR;
        #1;
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_ref_done: got %b expected 1", ddl_rdy_o);
        end
        ddl_cmd_i = K_ACTV;
        #1;
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_act_done: got %b expected 1", ddl_rdy_o);
        end
    endtask

    task automatic test_precharge();
        int waited;
        drive(1'b1, K_ACTV, 3'd1, 13'h055, 4'h0);
        tick();
        drive(1'b0, K_PREC, 3'd1, 13'h000, 4'h0);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_ba_o, dfi_adr_o} !== {4'b0011, 3'd1, 13'h055}) begin
            miscompares++;
            $display("FAIL act2_dfi: got cmd=%b ba=%0h adr=%0h expected 0011 1 055",
                     {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, dfi_ba_o, dfi_adr_o);
        end
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL tras_hold0: got %b expected 0", ddl_rdy_o);
        end
        tick();
        // Request PREC two cycles after ACT; tRAS must hold it until cycle 4.
        tick();
        ddl_req_i = 1'b1;
        #1;
        waited = 0;
        while (ddl_rdy_o !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        vectors++;
        if (waited !== 2) begin
            miscompares++;
            $display("FAIL tras_wait: got %0d extra cycles expected 2", waited);
        end
        tick();
        drive(1'b0, K_READ, 3'd0, 13'h0, 4'h0);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 4'b0010) begin
            miscompares++;
            $display("FAIL prec_dfi: got %b expected 0010", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o});
        end
    endtask

    task automatic test_illegal();
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL read_closed: got %b expected 0", ddl_rdy_o);
        end
        drive(1'b0, K_WRIT, 3'd0, 13'h0, 4'h0);
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL write_closed: got %b expected 0", ddl_rdy_o);
        end
        drive(1'b1, K_NOOP, 3'd0, 13'h0, 4'h0);
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL noop_rdy: got %b expected 1", ddl_rdy_o);
        end
        tick();
        drive(1'b0, K_ACTV, 3'd3, 13'h0AA, 4'h0);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 4'b0111) begin
            miscompares++;
            $display("FAIL noop_dfi: got %b expected 0111", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o});
        end
        repeat (2) tick();
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL trp_done: got %b expected 1", ddl_rdy_o);
        end
        ddl_req_i = 1'b1;
        tick();
        ddl_req_i = 1'b0;
        repeat (5) tick();
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL act_open: got %b expected 0", ddl_rdy_o);
        end
        drive(1'b0, K_MODE, 3'd0, 13'h0, 4'h0);
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_open: got %b expected 0", ddl_rdy_o);
        end
        drive(1'b0, K_ZQCL, 3'd0, 13'h0, 4'h0);
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL zqcl_open: got %b expected 0", ddl_rdy_o);
        end
        drive(1'b0, K_READ, 3'd3, 13'h0, 4'h0);
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL read_open: got %b expected 1", ddl_rdy_o);
        end
        drive(1'b1, K_PREC, 3'd3, 13'h0, 4'h0);
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL prec_rdy: got %b expected 1", ddl_rdy_o);
        end
        tick();
        drive(1'b0, K_ACTV, 3'd0, 13'h0, 4'h0);
    endtask

    task automatic test_refresh();
        repeat (3) tick();
        ref_en_i = 1'b1;
        repeat (779) tick();
        vectors++;
        if (ddl_ref_o !== 1'b0) begin
            miscompares++;
            $display("FAIL refi_early: got %b expected 0", ddl_ref_o);
        end
        tick();
        vectors++;
        if (ddl_ref_o !== 1'b1) begin
            miscompares++;
            $display("FAIL refi_due: got %b expected 1", ddl_ref_o);
        end
        drive(1'b1, K_REFR, 3'd0, 13'h0, 4'h0);
        vectors++;
        if (ddl_rdy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL refr_rdy: got %b expected 1", ddl_rdy_o);
        end
        tick();
        drive(1'b0, K_ACTV, 3'd0, 13'h0, 4'h0);
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 4'b0001) begin
            miscompares++;
            $display("FAIL refr_dfi: got %b expected 0001", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o});
        end
        for (int j = 0; j < 11; j++) begin
            vectors++;
            if ({ddl_ref_o, ddl_rdy_o} !== 2'b10) begin
                miscompares++;
                $display("FAIL trfc_busy[%0d]: got ref,rdy=%b expected 10", j, {ddl_ref_o, ddl_rdy_o});
            end
            tick();
        end
        vectors++;
        if ({ddl_ref_o, ddl_rdy_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL trfc_done: got ref,rdy=%b expected 01", {ddl_ref_o, ddl_rdy_o});
        end
        repeat (779) tick();
        vectors++;
        if (ddl_ref_o !== 1'b0) begin
            miscompares++;
            $display("FAIL refi2_early: got %b expected 0", ddl_ref_o);
        end
        tick();
        vectors++;
        if (ddl_ref_o !== 1'b1) begin
            miscompares++;
            $display("FAIL refi2_due: got %b expected 1", ddl_ref_o);
        end
    endtask

    task automatic test_reset_busy();
        drive(1'b1, K_REFR, 3'd5, 13'h1FF, 4'h0);
        tick();
        drive(1'b0, K_ACTV, 3'd0, 13'h0, 4'h0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_rden_o, dfi_wren_o, dfi_ba_o, dfi_adr_o}
            !== {4'b1111, 2'b00, 3'd0, 13'h0}) begin
            miscompares++;
            $display("FAIL busy_reset_dfi: got cmd=%b rden=%b wren=%b ba=%0h adr=%0h expected 1111 0 0 0 0",
                     {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, dfi_rden_o, dfi_wren_o, dfi_ba_o, dfi_adr_o);
        end
        vectors++;
        if ({ddl_ref_o, ddl_rdy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL busy_reset_ref: got ref,rdy=%b expected 00", {ddl_ref_o, ddl_rdy_o});
        end
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (ddl_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_release_rdy: got %b expected 0", ddl_rdy_o);
        end
        tick();
        vectors++;
        if ({ddl_ref_o, ddl_rdy_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} !== 6'b01_0111) begin
            miscompares++;
            $display("FAIL busy_after: got ref,rdy,cmd=%b expected 010111",
                     {ddl_ref_o, ddl_rdy_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o});
        end
    endtask

    initial begin
        test_reset();
        test_act_read();
        test_read_write();
        test_write_ap();
        test_precharge();
        test_illegal();
        test_refresh();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
